// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle: request/grant/response handshake between the MEM-stage
// load/store unit (master) and the data memory (slave).
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [STRB_W-1:0] dm_wstrb;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one request/grant/response transaction per
// aligned load/store, formats load data and stalls the pipeline until completion.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_mem_read,
    input  logic               MEM_mem_write,
    input  logic [2:0]         MEM_funct3,
    input  logic [ADDR_W-1:0]  MEM_addr,
    input  logic [DATA_W-1:0]  MEM_store_data,
    mem_access_unit_if.master  dm,
    output logic [DATA_W-1:0]  DM_rd_data,
    output logic               mem_stall,
    output logic               misalign
);
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic               acc;
    logic [1:0]         a;
    logic               is_word;
    logic               is_half;
    logic               misaligned;
    logic [DATA_W-1:0]  st_wdata;
    logic [STRB_W-1:0]  st_wstrb;
    logic [2:0]         ld_funct3;
    logic [1:0]         ld_off;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [DATA_W-1:0]  ld_fmt;

    // Access decode; unused funct3 encodings (x11, 110) fall into the word case.
    assign acc        = MEM_mem_read | MEM_mem_write;
    assign a          = MEM_addr[1:0];
    assign is_word    = MEM_funct3[1];
    assign is_half    = (MEM_funct3[1:0] == 2'b01);
    assign misaligned = (is_half & a[0]) | (is_word & (a != 2'b00));

    assign misalign  = acc & misaligned;
    assign mem_stall = acc & ~misaligned & (state != DONE);

    // Store lane replication and byte strobes.
    always_comb begin
        st_wdata = MEM_store_data;
        st_wstrb = 4'b1111;
        if (!is_word) begin
            if (is_half) begin
                st_wdata = {2{MEM_store_data[15:0]}};
                st_wstrb = 4'b0011 << a;
            end else begin
                st_wdata = {4{MEM_store_data[7:0]}};
                st_wstrb = 4'b0001 << a;
            end
        end
    end

    // Load lane extraction uses the offset/funct3 captured when the request was issued.
    always_comb begin
        ld_byte = dm.dm_rdata[7:0];
        case (ld_off)
            2'd0:    ld_byte = dm.dm_rdata[7:0];
            2'd1:    ld_byte = dm.dm_rdata[15:8];
            2'd2:    ld_byte = dm.dm_rdata[23:16];
            default: ld_byte = dm.dm_rdata[31:24];
        endcase
        ld_half = ld_off[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
        case (ld_funct3)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = dm.dm_rdata;
        endcase
    end

    // Transaction FSM with registered bus payload and load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 1'b0;
            dm.dm_addr  <= '0;
            dm.dm_wstrb <= '0;
            dm.dm_wdata <= '0;
            DM_rd_data  <= '0;
            ld_funct3   <= 3'd0;
            ld_off      <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc && !misaligned) begin
                        dm.dm_req   <= 1'b1;
                        dm.dm_we    <= ~MEM_mem_read;
                        dm.dm_addr  <= {MEM_addr[ADDR_W-1:2], 2'b00};
                        dm.dm_wstrb <= MEM_mem_read ? 4'b0000 : st_wstrb;
                        dm.dm_wdata <= st_wdata;
                        ld_funct3   <= MEM_funct3;
                        ld_off      <= a;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (dm.dm_gnt) begin
                        dm.dm_req <= 1'b0;
                        state     <= dm.dm_we ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (dm.dm_rvalid) begin
                        DM_rd_data <= ld_fmt;
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of loads/stores plus
// hand-written reset, grant-stall and back-to-back sequences.
module tb_mem_access_unit;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read;
    logic          mem_write;
    logic [2:0]    funct3;
    logic [31:0]   addr;
    logic [31:0]   sdata;
    logic [31:0]   rd_data;
    logic          stall;
    logic          mis;

    mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) dmif ();

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_mem_read   (mem_read),
        .MEM_mem_write  (mem_write),
        .MEM_funct3     (funct3),
        .MEM_addr       (addr),
        .MEM_store_data (sdata),
        .dm             (dmif),
        .DM_rd_data     (rd_data),
        .mem_stall      (stall),
        .misalign       (mis)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] ad;
        logic [31:0] sd;
        logic [31:0] rdat;
        logic        ms;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_rd;
    } vec_t;

    localparam int NV = 14;
    vec_t        vecs [NV];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] ad, input logic [31:0] sd,
                                input logic [31:0] rdat, input logic ms,
                                input logic [31:0] ea, input logic [31:0] ew,
                                input logic [3:0] es, input logic [31:0] er);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.ad = ad; v.sd = sd; v.rdat = rdat;
        v.ms = ms; v.e_addr = ea; v.e_wdata = ew; v.e_wstrb = es; v.e_rd = er;
        return v;
    endfunction

    task automatic drop_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
    endtask

    // Memory model: grant in the first REQ cycle (with a decoy rvalid), rvalid one cycle later.
    task automatic run_txn(input vec_t v, input bit chained, input int id);
        int stalls = 0;
        bit granted = 0;
        bit seen = 0;
        bit done = 0;
        mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.ad; sdata = v.sd;
        dmif.dm_rdata = v.rdat;
        if (chained) begin
            #1;
            chk($sformatf("v%0d_done_stall", id), 32'(stall), 32'd0);
            @(negedge clk);
        end
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            dmif.dm_gnt = 1'b0; dmif.dm_rvalid = 1'b0; dmif.dm_rdata = v.rdat;
            if (!stall) begin
                done = 1;
            end else begin
                stalls++;
                if (dmif.dm_req) begin
                    if (!seen) begin
                        seen = 1;
                        chk($sformatf("v%0d_addr", id), dmif.dm_addr, v.e_addr);
                        chk($sformatf("v%0d_we", id), 32'(dmif.dm_we), 32'(!v.rd));
                        chk($sformatf("v%0d_wstrb", id), 32'(dmif.dm_wstrb), 32'(v.e_wstrb));
                        if (!v.rd) chk($sformatf("v%0d_wdata", id), dmif.dm_wdata, v.e_wdata);
                    end
                    dmif.dm_gnt = 1'b1;
                    if (v.rd) begin
                        dmif.dm_rvalid = 1'b1;
                        dmif.dm_rdata  = ~v.rdat;
                    end
                    granted = 1;
                end else if (granted) begin
                    dmif.dm_rvalid = 1'b1;
                end
                @(negedge clk);
            end
        end
        chk($sformatf("v%0d_finished", id), 32'(done), 32'd1);
        chk($sformatf("v%0d_stall_cycles", id), 32'(stalls), v.rd ? 32'd3 : 32'd2);
        if (v.rd) begin
            chk($sformatf("v%0d_rd_data", id), rd_data, v.e_rd);
            last_rd = v.e_rd;
        end
        chk($sformatf("v%0d_req_done", id), 32'(dmif.dm_req), 32'd0);
    endtask

    task automatic run_mis(input vec_t v, input int id);
        bit any_req = 0;
        mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.ad; sdata = v.sd;
        dmif.dm_rdata = v.rdat;
        #1;
        chk($sformatf("v%0d_misalign", id), 32'(mis), 32'd1);
        chk($sformatf("v%0d_mis_stall", id), 32'(stall), 32'd0);
        repeat (3) begin
            dmif.dm_gnt = 1'b1; dmif.dm_rvalid = 1'b1;
            @(negedge clk); #1;
            if (dmif.dm_req) any_req = 1;
        end
        dmif.dm_gnt = 1'b0; dmif.dm_rvalid = 1'b0;
        chk($sformatf("v%0d_mis_req", id), 32'(any_req), 32'd0);
        chk($sformatf("v%0d_mis_rd", id), rd_data, last_rd);
        drop_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int reqc;
        bit stable;

        vecs[0]  = mk(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 32'h0000_1000, 32'h0, 4'b0000, 32'hFFFF_FF80);
        vecs[1]  = mk(1, 0, 3'b101, 32'h0000_0002, 32'h0, 32'h9ABC_0000, 0, 32'h0000_0000, 32'h0, 4'b0000, 32'h0000_9ABC);
        vecs[2]  = mk(1, 0, 3'b001, 32'h0000_0002, 32'h0, 32'h9ABC_0000, 0, 32'h0000_0000, 32'h0, 4'b0000, 32'hFFFF_9ABC);
        vecs[3]  = mk(1, 0, 3'b100, 32'h0000_1002, 32'h0, 32'h80FF_1234, 0, 32'h0000_1000, 32'h0, 4'b0000, 32'h0000_00FF);
        vecs[4]  = mk(1, 0, 3'b000, 32'h0000_1002, 32'h0, 32'h80FF_1234, 0, 32'h0000_1000, 32'h0, 4'b0000, 32'hFFFF_FFFF);
        vecs[5]  = mk(1, 0, 3'b010, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0, 32'h0000_4000, 32'h0, 4'b0000, 32'hDEAD_BEEF);
        vecs[6]  = mk(0, 1, 3'b001, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0, 0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 32'h0);
        vecs[7]  = mk(0, 1, 3'b000, 32'h0000_2001, 32'h1234_56A5, 32'h0, 0, 32'h0000_2000, 32'hA5A5_A5A5, 4'b0010, 32'h0);
        vecs[8]  = mk(0, 1, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 0, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111, 32'h0);
        vecs[9]  = mk(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h1111_1111, 1, 32'h0, 32'h0, 4'b0000, 32'h0);
        vecs[10] = mk(0, 1, 3'b001, 32'h0000_2003, 32'h5555_6666, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 32'h0);
        vecs[11] = mk(1, 0, 3'b011, 32'h0000_5004, 32'h0, 32'h1122_3344, 0, 32'h0000_5004, 32'h0, 4'b0000, 32'h1122_3344);
        vecs[12] = mk(1, 1, 3'b000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_007F, 0, 32'h0000_0000, 32'h0, 4'b0000, 32'h0000_007F);
        vecs[13] = mk(1, 0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_8000, 0, 32'h0000_0000, 32'h0, 4'b0000, 32'h0000_0080);

        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 32'h0; sdata = 32'h0;
        dmif.dm_gnt = 1'b0; dmif.dm_rvalid = 1'b0; dmif.dm_rdata = 32'h0;
        #2;
        chk("rst_req", 32'(dmif.dm_req), 32'd0);
        chk("rst_we", 32'(dmif.dm_we), 32'd0);
        chk("rst_addr", dmif.dm_addr, 32'h0);
        chk("rst_wstrb", 32'(dmif.dm_wstrb), 32'd0);
        chk("rst_wdata", dmif.dm_wdata, 32'h0);
        chk("rst_rd", rd_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset while waiting for read data, then a late rvalid.
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_6000; dmif.dm_rdata = 32'h5555_AAAA;
        @(negedge clk); #1;
        chk("rw_req", 32'(dmif.dm_req), 32'd1);
        dmif.dm_gnt = 1'b1;
        @(negedge clk); #1;
        dmif.dm_gnt = 1'b0;
        chk("rw_wait_req", 32'(dmif.dm_req), 32'd0);
        chk("rw_wait_stall", 32'(stall), 32'd1);
        rst = 1'b0; #1;
        chk("rw_rst_req", 32'(dmif.dm_req), 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1; #1;
        dmif.dm_rvalid = 1'b1;
        @(negedge clk); #1;
        dmif.dm_rvalid = 1'b0;
        chk("rw_late_rd", rd_data, 32'h0);
        chk("rw_late_req", 32'(dmif.dm_req), 32'd0);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].ms) begin
                run_mis(vecs[i], i);
            end else begin
                run_txn(vecs[i], 1'b0, i);
                drop_inputs();
            end
        end

        // Store with grant withheld for five REQ cycles.
        mem_write = 1'b1; funct3 = 3'b010; addr = 32'h0000_7008; sdata = 32'h0BAD_CAFE;
        stalls = 0; reqc = 0; stable = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            dmif.dm_gnt = 1'b0;
            if (!stall) break;
            stalls++;
            if (dmif.dm_req) begin
                reqc++;
                if (dmif.dm_addr !== 32'h0000_7008 || dmif.dm_we !== 1'b1 ||
                    dmif.dm_wstrb !== 4'b1111 || dmif.dm_wdata !== 32'h0BAD_CAFE) stable = 0;
                if (reqc == 6) dmif.dm_gnt = 1'b1;
            end
            @(negedge clk);
        end
        chk("gw_payload_stable", 32'(stable), 32'd1);
        chk("gw_req_cycles", 32'(reqc), 32'd6);
        chk("gw_stall_cycles", 32'(stalls), 32'd7);
        chk("gw_req_after", 32'(dmif.dm_req), 32'd0);
        drop_inputs();

        // Back-to-back loads: second one presented during the first one's DONE cycle.
        run_txn(vecs[1], 1'b0, 100);
        run_txn(vecs[0], 1'b1, 101);
        drop_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
